data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp_if.sv | 25 ++
 rtl/data_mem_resp.sv | 95 +++++++++
 tb/tb_data_mem_resp.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_resp_if.sv
// Request/response handshake between the CPU memory stage and data_mem_resp.
// The shared data bus is a separate inout port on the memory block.
interface data_mem_resp_if;
  logic        mem_req;
  logic        mem_rw;
  logic [63:0] mem_addr;
  logic        mem_ready;
  logic        mem_err;

  modport master (
    output mem_req,
    output mem_rw,
    output mem_addr,
    input  mem_ready,
    input  mem_err
  );

  modport slave (
    input  mem_req,
    input  mem_rw,
    input  mem_addr,
    output mem_ready,
    output mem_err
  );
endinterface

// File: rtl/data_mem_resp.sv
// Fixed-latency 64-bit data memory with one-cycle response and shared bus.
// Accepts one access in IDLE, waits LATENCY cycles, then answers in RESP.
module data_mem_resp #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_resp_if.slave bus,
  inout  wire  [63:0]   mem_data
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 =
    (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [60:0] DEPTH_W = 61'(DEPTH);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   mem_q [DEPTH];

  logic          valid;
  logic          drive;
  logic [IW-1:0] idx;
  logic [63:0]   rdata;

  assign valid = (addr_q[2:0] == 3'b000)
              && (addr_q[63:3] < DEPTH_W);
  assign idx   = addr_q[3 +: IW];
  assign rdata = valid ? mem_q[idx] : 64'h0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          rw_d    = bus.mem_rw;
          addr_d  = bus.mem_addr;
          wdata_d = mem_data;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over everything, including a store finishing in RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      addr_q  <= 64'h0;
      wdata_q <= 64'h0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 64'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (state_q == RESP && rw_q && valid)
        mem_q[idx] <= wdata_q;
    end
  end

  assign bus.mem_ready = (state_q == RESP);
  assign bus.mem_err   = (state_q == RESP) && !valid;
  assign drive         = (state_q == RESP) && !rw_q;
  assign mem_data      = drive ? rdata : 64'bz;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: LATENCY=2 and LATENCY=0 instances.
// Released bus lines are pulled up, so a floating bus reads all ones.
module tb_data_mem_resp;

  localparam logic [63:0] HIZ = '1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_resp_if if0 ();
  data_mem_resp_if if1 ();

  tri1 [63:0] bus0;
  tri1 [63:0] bus1;
  logic        drv0 = 1'b0;
  logic        drv1 = 1'b0;
  logic [63:0] wd0  = '0;
  logic [63:0] wd1  = '0;

  assign bus0 = drv0 ? wd0 : 64'bz;
  assign bus1 = drv1 ? wd1 : 64'bz;

  data_mem_resp #(.DEPTH(32), .LATENCY(2)) u0 (
    .clk      (clk),
    .rst      (rst),
    .bus      (if0.slave),
    .mem_data (bus0)
  );

  data_mem_resp #(.DEPTH(32), .LATENCY(0)) u1 (
    .clk      (clk),
    .rst      (rst),
    .bus      (if1.slave),
    .mem_data (bus1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic setin(input bit sel, input logic req,
                       input logic rw, input logic [63:0] a,
                       input logic drv, input logic [63:0] d);
    if (sel) begin
      if1.mem_req  = req;
      if1.mem_rw   = rw;
      if1.mem_addr = a;
      drv1 = drv;
      wd1  = d;
    end else begin
      if0.mem_req  = req;
      if0.mem_rw   = rw;
      if0.mem_addr = a;
      drv0 = drv;
      wd0  = d;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? if1.mem_ready : if0.mem_ready;
  endfunction

  function automatic logic err(input bit sel);
    return sel ? if1.mem_err : if0.mem_err;
  endfunction

  function automatic logic [63:0] dbus(input bit sel);
    return sel ? bus1 : bus0;
  endfunction

  // One access; n = edges from first request edge until mem_ready seen.
  task automatic acc(input bit sel, input logic rw,
                     input logic [63:0] a, input logic [63:0] d,
                     output int n, output logic [63:0] rd,
                     output logic er);
    bit got;
    got = 0;
    n   = 0;
    rd  = '0;
    er  = 1'b0;
    setin(sel, 1'b1, rw, a, rw, d);
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) setin(sel, 1'b1, ~rw, ~a, 1'b0, ~d);
      #1;
      if (rdy(sel)) begin
        got = 1;
        rd  = dbus(sel);
        er  = err(sel);
      end
    end
    setin(sel, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    @(posedge clk);
    #1;
    chk("post_rdy", {63'h0, rdy(sel)}, 64'h0);
    chk("post_err", {63'h0, err(sel)}, 64'h0);
    chk("post_bus", dbus(sel), HIZ);
  endtask

  int          n;
  logic [63:0] rd;
  logic        er;
  int          pulses;
  logic [63:0] ea;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    setin(0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    setin(1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy0", {63'h0, if0.mem_ready}, 64'h0);
    chk("rst_err0", {63'h0, if0.mem_err}, 64'h0);
    chk("rst_bus0", bus0, HIZ);
    chk("rst_rdy1", {63'h0, if1.mem_ready}, 64'h0);
    chk("rst_bus1", bus1, HIZ);

    // request under reset must not be accepted
    setin(0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prio", {63'h0, if0.mem_ready}, 64'h0);
    rst = 1'b1;

    acc(0, 1'b0, 64'h0, 64'h0, n, rd, er);
    chk("ld0_lat", 64'(n), 64'd3);
    chk("ld0_data", rd, 64'h0);
    chk("ld0_err", {63'h0, er}, 64'h0);

    acc(0, 1'b1, 64'h18, 64'hDEADBEEF_CAFEF00D, n, rd, er);
    chk("st18_lat", 64'(n), 64'd3);
    chk("st18_bus", rd, HIZ);
    chk("st18_err", {63'h0, er}, 64'h0);

    acc(0, 1'b0, 64'h18, 64'h0, n, rd, er);
    chk("ld18_data", rd, 64'hDEADBEEF_CAFEF00D);
    chk("ld18_err", {63'h0, er}, 64'h0);

    acc(0, 1'b1, 64'h0, 64'h1111, n, rd, er);
    acc(0, 1'b1, 64'hF8, 64'h3131, n, rd, er);
    chk("st_f8_err", {63'h0, er}, 64'h0);

    acc(0, 1'b0, 64'h1C, 64'h0, n, rd, er);
    chk("ld1c_err", {63'h0, er}, 64'h1);
    chk("ld1c_data", rd, 64'h0);
    chk("ld1c_lat", 64'(n), 64'd3);

    acc(0, 1'b1, 64'h100, 64'hBAD, n, rd, er);
    chk("st100_err", {63'h0, er}, 64'h1);

    acc(0, 1'b0, 64'h0, 64'h0, n, rd, er);
    chk("w0_keep", rd, 64'h1111);
    acc(0, 1'b0, 64'hF8, 64'h0, n, rd, er);
    chk("w31_keep", rd, 64'h3131);

    // back-to-back: accepts on edges 1,5,9,13; responses on 3,7,11,15
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      ea = ((k >> 2) & 1) != 0 ? 64'h18 : 64'h0;
      setin(0, 1'b1, 1'b0, ea, 1'b0, 64'h0);
      @(posedge clk);
      #1;
      if (if0.mem_ready) pulses++;
      chk($sformatf("cont_rdy%0d", k), {63'h0, if0.mem_ready},
          {63'h0, (k % 4) == 3});
      if ((k % 4) == 3)
        chk($sformatf("cont_dat%0d", k), bus0,
            (((k - 2) >> 2) & 1) != 0 ?
              64'hDEADBEEF_CAFEF00D : 64'h1111);
    end
    setin(0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    chk("cont_pulses", 64'(pulses), 64'd4);

    // reset while a store waits: aborted, storage cleared
    setin(0, 1'b1, 1'b1, 64'h8, 1'b1, 64'h0808_0808_0808_0808);
    @(posedge clk);
    #1;
    setin(0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_rdy", {63'h0, if0.mem_ready}, 64'h0);
    chk("abort_bus", bus0, HIZ);
    rst = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (if0.mem_ready) pulses++;
    end
    chk("abort_pulses", 64'(pulses), 64'd0);
    acc(0, 1'b0, 64'h8, 64'h0, n, rd, er);
    chk("abort_w1", rd, 64'h0);
    acc(0, 1'b0, 64'h18, 64'h0, n, rd, er);
    chk("clr_w3", rd, 64'h0);

    // zero-latency instance
    acc(1, 1'b1, 64'h10, 64'h55AA_0123_4567_89AB, n, rd, er);
    chk("l0_st_lat", 64'(n), 64'd1);
    chk("l0_st_bus", rd, HIZ);
    chk("l0_st_err", {63'h0, er}, 64'h0);
    acc(1, 1'b0, 64'h10, 64'h0, n, rd, er);
    chk("l0_ld_lat", 64'(n), 64'd1);
    chk("l0_ld_data", rd, 64'h55AA_0123_4567_89AB);
    acc(1, 1'b0, 64'h108, 64'h0, n, rd, er);
    chk("l0_oob_err", {63'h0, er}, 64'h1);
    chk("l0_oob_data", rd, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
